// File: rtl/interrupt_controller_pkg.sv
// rtl/interrupt_controller_pkg.sv - shared constants, state type and id helper for the interrupt controller
package interrupt_controller_pkg;

   localparam int INTC_WIDTH = 64;
   localparam int INTC_NSRC  = 8;

   localparam logic [63:0] INTC_MASK_ADDR  = 64'h0000_0000_1000_0000;
   localparam logic [63:0] INTC_PEND_ADDR  = 64'h0000_0000_1000_0008;
   localparam logic [63:0] INTC_CLAIM_ADDR = 64'h0000_0000_1000_0010;
   localparam logic [63:0] INTC_DONE_ADDR  = 64'h0000_0000_1000_0018;

   typedef enum logic {INTC_IDLE, INTC_CLAIMED} intc_state_t;

   // Source id n (1..31) maps to bit n-1; id 0 means "no source".
   function automatic logic [31:0] intc_id_onehot(input logic [4:0] id);
      if (id == 5'd0) return 32'd0;
      return 32'd1 << (id - 5'd1);
   endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// rtl/interrupt_controller_if.sv - data bus signals seen by the interrupt controller
interface interrupt_controller_if #(parameter int WIDTH = 64);
   logic [WIDTH-1:0] address;
   logic [WIDTH-1:0] data;
   logic             MemRead;
   logic             MemWrite;
   logic             IntcAddress;

   modport master (output address, data, MemRead, MemWrite, input IntcAddress);
   modport slave  (input address, data, MemRead, MemWrite, output IntcAddress);
endinterface

// File: rtl/interrupt_controller_priority_enc.sv
// rtl/interrupt_controller_priority_enc.sv - lowest-index-wins priority encoder
module intc_priority_enc #(
   parameter int  NSRC  = 8,
   localparam int WIN_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
   input  logic [NSRC-1:0]  i_eligible,
   output logic             o_valid,
   output logic [WIN_W-1:0] o_win
);

   // Scan downward so the last hit (lowest index) wins.
   always_comb begin
      o_valid = 1'b0;
      o_win   = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (i_eligible[i]) begin
            o_valid = 1'b1;
            o_win   = WIN_W'(i);
         end
      end
   end

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - pending/mask latch, claim/complete FSM and MMIO decode
module interrupt_controller
   import interrupt_controller_pkg::*;
#(
   parameter int WIDTH = INTC_WIDTH,
   parameter int NSRC  = INTC_NSRC
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NSRC-1:0]        irq_src,
   interrupt_controller_if.slave  bus,
   output wire  [WIDTH-1:0]       rdata,
   output logic                   irq_out,
   output logic [NSRC-1:0]        irq_ack
);

   localparam int WIN_W = (NSRC > 1) ? $clog2(NSRC) : 1;

   intc_state_t       r_state;
   logic [NSRC-1:0]   r_mask;
   logic [NSRC-1:0]   r_pending;
   logic [NSRC-1:0]   r_src_prev;
   logic [NSRC-1:0]   r_irq_ack;
   logic              r_irq_out;
   logic [4:0]        r_in_service;

   logic [NSRC-1:0]   w_rise;
   logic [NSRC-1:0]   w_eligible;
   logic              w_valid;
   logic [WIN_W-1:0]  w_win;
   logic [4:0]        w_cid;
   logic [NSRC-1:0]   w_claim_clr;
   logic [NSRC-1:0]   w_pending_next;
   logic              w_hit_mask, w_hit_pend, w_hit_claim, w_hit_done;
   logic              w_do_claim, w_do_done;
   logic              w_rd_active;
   logic [WIDTH-1:0]  w_rdata;
   intc_state_t       w_state_next;
   logic              w_unused;

   assign w_rise     = irq_src & ~r_src_prev;
   assign w_eligible = r_pending & r_mask;

   intc_priority_enc #(.NSRC(NSRC)) u_prio (
      .i_eligible (w_eligible),
      .o_valid    (w_valid),
      .o_win      (w_win)
   );

   assign w_cid = w_valid ? (5'(w_win) + 5'd1) : 5'd0;

   assign w_hit_mask  = (bus.address == WIDTH'(INTC_MASK_ADDR));
   assign w_hit_pend  = (bus.address == WIDTH'(INTC_PEND_ADDR));
   assign w_hit_claim = (bus.address == WIDTH'(INTC_CLAIM_ADDR));
   assign w_hit_done  = (bus.address == WIDTH'(INTC_DONE_ADDR));
   assign bus.IntcAddress = w_hit_mask | w_hit_pend | w_hit_claim | w_hit_done;

   assign w_do_claim = (r_state == INTC_IDLE) && bus.MemRead && w_hit_claim && w_valid;
   assign w_do_done  = (r_state == INTC_CLAIMED) && bus.MemWrite && w_hit_done &&
                       (bus.data[4:0] == r_in_service);

   // A fresh rising edge re-sets a bit even if it is being claimed this cycle.
   assign w_claim_clr    = w_do_claim ? NSRC'(intc_id_onehot(w_cid)) : '0;
   assign w_pending_next = (r_pending & ~w_claim_clr) | w_rise;

   always_comb begin
      w_state_next = r_state;
      if (w_do_claim)     w_state_next = INTC_CLAIMED;
      else if (w_do_done) w_state_next = INTC_IDLE;
   end

   always_comb begin
      w_rdata = '0;
      if (w_hit_mask)                               w_rdata = WIDTH'(r_mask);
      else if (w_hit_pend)                          w_rdata = WIDTH'(r_pending);
      else if (w_hit_claim && r_state == INTC_IDLE) w_rdata = WIDTH'(w_cid);
   end

   assign w_rd_active = bus.MemRead && bus.IntcAddress;
   assign rdata       = w_rd_active ? w_rdata : {WIDTH{1'bz}};
   assign w_unused    = &{1'b0, bus.data};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state      <= INTC_IDLE;
         r_mask       <= '0;
         r_pending    <= '0;
         r_src_prev   <= '0;
         r_irq_ack    <= '0;
         r_irq_out    <= 1'b0;
         r_in_service <= 5'd0;
      end else begin
         r_src_prev <= irq_src;
         r_pending  <= w_pending_next;
         r_irq_out  <= (w_state_next == INTC_IDLE) && (|w_eligible);
         r_irq_ack  <= '0;
         if (bus.MemWrite && w_hit_mask) r_mask <= bus.data[NSRC-1:0];
         case (r_state)
            INTC_IDLE: begin
               if (w_do_claim) begin
                  r_state      <= INTC_CLAIMED;
                  r_in_service <= w_cid;
               end
            end
            INTC_CLAIMED: begin
               if (w_do_done) begin
                  r_irq_ack    <= NSRC'(intc_id_onehot(r_in_service));
                  r_in_service <= 5'd0;
                  r_state      <= INTC_IDLE;
               end
            end
            default: r_state <= INTC_IDLE;
         endcase
      end
   end

   assign irq_out = r_irq_out;
   assign irq_ack = r_irq_ack;

endmodule
